// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory model.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W     = 4;
   localparam int NUM_LANES = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte-lane write enables and a registered read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic [NUM_LANES-1:0] we,
   input  logic                 re,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: the array and its read register have no reset; contents are undefined until
   // written, and a reset branch here would turn the RAM into a huge flop bank.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one transaction at a time with a fixed LATENCY.
// Define DMEM_ERR_CHECK_EN to flag out-of-range and misaligned word accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int ADDR_W = $clog2(DEPTH);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              commit;
   logic              accept;
   logic              req_err;

   logic              h_we, h_err;
   logic [ADDR_W-1:0] h_idx;
   logic [31:0]       h_wdata;
   logic [3:0]        h_be;

   logic              cur_we, cur_err;
   logic [ADDR_W-1:0] cur_idx;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_be;

   logic [3:0]        ram_we;
   logic              ram_re;
   logic [31:0]       ram_rdata;

`ifdef DMEM_ERR_CHECK_EN
   assign req_err = (|req_addr[31:ADDR_W+2]) || ((|req_addr[1:0]) && (req_be == 4'b1111));
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
   assign req_err          = 1'b0;
`endif

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // With LATENCY==1 the access happens on the acceptance edge, before the holding
   // registers are loaded, so the array is fed straight from the request in IDLE.
   always_comb begin
      if (state == IDLE) begin
         cur_we    = req_we;
         cur_err   = req_err;
         cur_idx   = req_addr[ADDR_W+1:2];
         cur_wdata = req_wdata;
         cur_be    = req_be;
      end else begin
         cur_we    = h_we;
         cur_err   = h_err;
         cur_idx   = h_idx;
         cur_wdata = h_wdata;
         cur_be    = h_be;
      end
   end

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_nx = RESP;
                  commit   = 1'b1;
               end else begin
                  state_nx = BUSY;
                  cnt_nx   = CNT_W'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            if (cnt > CNT_W'(1)) begin
               cnt_nx = cnt - CNT_W'(1);
            end else begin
               state_nx = RESP;
               cnt_nx   = '0;
               commit   = 1'b1;
            end
         end
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         h_we    <= 1'b0;
         h_err   <= 1'b0;
         h_idx   <= '0;
         h_wdata <= '0;
         h_be    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            h_we    <= req_we;
            h_err   <= req_err;
            h_idx   <= req_addr[ADDR_W+1:2];
            h_wdata <= req_wdata;
            h_be    <= req_be;
         end
      end
   end

   assign ram_we = (commit && cur_we && !cur_err) ? cur_be : 4'b0000;
   assign ram_re = commit && !cur_we && !cur_err;

   dmem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (cur_idx),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   // The read register only loads on the RESP-entry edge, so data is stable through RESP.
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = (rsp_valid && !h_we && !h_err) ? ram_rdata : 32'h0;
   assign rsp_err   = rsp_valid && h_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_dmem_responder;

   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [3:0]  a_req_be;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_be;

   dmem_responder #(.DEPTH(256), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_responder #(.DEPTH(256), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pat(input int k);
      return 32'hC0DE_0000 + 32'(k * 32'h111);
   endfunction

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] rdata, input logic err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rdata = rdata; v.err = err;
      return v;
   endfunction

   // One transaction on the LATENCY=2 instance; hold>0 keeps rsp_ready low that many cycles.
   task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] er, input logic ee, input int hold);
      int   n;
      exp_t e;
      @(negedge clk);
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      a_req_be    = be;
      a_req_valid = 1'b1;
      a_rsp_ready = (hold == 0);
      n = 0;
      while (!a_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_accept_wait", 32'(n), 32'd0);
      e.rdata = er;
      e.err   = ee;
      sb.push_back(e);
      @(negedge clk);
      a_req_valid = 1'b0;
      n = 1;
      while (!a_rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_latency", 32'(n), 32'(LAT_A));
      e = sb.pop_front();
      check("a_rdata", a_rsp_rdata, e.rdata);
      check("a_err", 32'(a_rsp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(a_rsp_valid), 32'd1);
         check("bp_rdata", a_rsp_rdata, e.rdata);
         check("bp_req_ready", 32'(a_req_ready), 32'd0);
      end
      a_rsp_ready = 1'b1;
      @(negedge clk);
      check("a_post_valid", 32'(a_rsp_valid), 32'd0);
      check("a_post_rdata", a_rsp_rdata, 32'h0);
      check("a_post_ready", 32'(a_req_ready), 32'd1);
   endtask

   // Four back-to-back transactions on the LATENCY=1 instance, req_valid held high.
   task automatic b_burst(input logic we);
      int   n;
      int   last;
      exp_t e;
      last = 0;
      b_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b_req_we    = we;
         b_req_addr  = 32'h40 + 32'(k * 4);
         b_req_wdata = pat(k);
         b_req_be    = 4'hF;
         b_req_valid = 1'b1;
         n = 0;
         while (!b_req_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (k > 0) check("b_period", 32'(cyc - last), 32'd2);
         last = cyc;
         e.rdata = we ? 32'h0 : pat(k);
         e.err   = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         check("b_valid", 32'(b_rsp_valid), 32'd1);
         e = sb.pop_front();
         check("b_rdata", b_rsp_rdata, e.rdata);
         check("b_err", 32'(b_rsp_err), 32'(e.err));
      end
      b_req_valid = 1'b0;
      @(negedge clk);
      check("b_idle_ready", 32'(b_req_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w10;
      rst = 1'b0;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
      a_rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
      b_rsp_ready = 1'b1;

      vt.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEAA, 1'b0));
      vt.push_back(mk(1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEAA, 1'b0));
      vt.push_back(mk(1'b1, 32'h14, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0));
      vt.push_back(mk(1'b1, 32'h14, 32'h11223344, 4'hA, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, 32'h14, 32'h0,        4'h0, 32'h11BB33DD, 1'b0));
      vt.push_back(mk(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0));
      vt.push_back(mk(1'b1, 32'h00, 32'h01020304, 4'hF, 32'h0,        1'b0));
`ifdef DMEM_ERR_CHECK_EN
      vt.push_back(mk(1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1));
      vt.push_back(mk(1'b1, 32'h12,  32'h77777777, 4'hF, 32'h0,        1'b1));
      vt.push_back(mk(1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0));
      w10 = 32'hDEADBEAA;
`else
      vt.push_back(mk(1'b0, 32'h400, 32'h0,        4'hF, 32'h01020304, 1'b0));
      vt.push_back(mk(1'b1, 32'h12,  32'h77777777, 4'hF, 32'h0,        1'b0));
      vt.push_back(mk(1'b0, 32'h10,  32'h0,        4'hF, 32'h77777777, 1'b0));
      w10 = 32'h77777777;
`endif

      repeat (2) @(negedge clk);
      check("rst_a_req_ready", 32'(a_req_ready), 32'd1);
      check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("rst_a_rsp_rdata", a_rsp_rdata, 32'h0);
      check("rst_a_rsp_err", 32'(a_rsp_err), 32'd0);
      check("rst_b_req_ready", 32'(b_req_ready), 32'd1);
      check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
      rst = 1'b1;

      foreach (vt[i]) a_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].rdata, vt[i].err, 0);

      // Response backpressure for five cycles.
      a_txn(1'b0, 32'h10, 32'h0, 4'hF, w10, 1'b0, 5);

      // Reset while a store is in BUSY: the store must be dropped.
      @(negedge clk);
      a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h55AA55AA; a_req_be = 4'hF;
      a_req_valid = 1'b1; a_rsp_ready = 1'b1;
      check("mid_pre_ready", 32'(a_req_ready), 32'd1);
      @(negedge clk);
      a_req_valid = 1'b0;
      check("mid_busy_ready", 32'(a_req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_req_ready", 32'(a_req_ready), 32'd1);
      check("mid_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("mid_rst_rsp_rdata", a_rsp_rdata, 32'h0);
      check("mid_rst_rsp_err", 32'(a_rsp_err), 32'd0);
      @(negedge clk);
      check("mid_rst_hold_valid", 32'(a_rsp_valid), 32'd0);
      rst = 1'b1;
      a_txn(1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0);

      // LATENCY=1 back-to-back: preload then read back.
      @(negedge clk);
      b_burst(1'b1);
      b_burst(1'b0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
